// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus writeback path.
package cdb_arbiter_pkg;

    localparam int FU_NUM = 4;
    localparam int ROB_W  = 4;
    localparam int PHYS_W = 6;
    localparam int DW     = 32;

    // Issue-queue entry handed to the functional units.
    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [1:0]        epoch;
        logic [7:0]        opcode;
        logic [PHYS_W-1:0] ps1;
        logic [PHYS_W-1:0] ps2;
        logic [PHYS_W-1:0] pd;
    } rs_uop_t;

    // Result packet a functional unit puts on the CDB.
    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [1:0]        epoch;
        logic              mispredict;
        logic [PHYS_W-1:0] pd;
        logic [DW-1:0]     data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin selector: first requester at or after ptr, scanning upward mod N.
module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N     = FU_NUM,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Rotate the scan start to ptr and take the first set request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per FU, round-robin broadcast with backpressure.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FU_NUM = cdb_arbiter_pkg::FU_NUM,
    parameter int ROB_W  = cdb_arbiter_pkg::ROB_W,
    parameter int PHYS_W = cdb_arbiter_pkg::PHYS_W,
    parameter int DW     = cdb_arbiter_pkg::DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FU_NUM-1:0]       fu_valid,
    output logic [FU_NUM-1:0]       fu_ready,
    input  cdb_pkt_t [FU_NUM-1:0]   fu_result,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ROB_W-1:0]        wb_rob_idx,
    output logic [1:0]              wb_epoch,
    output logic                    wb_mispredict,
    output logic [PHYS_W-1:0]       wb_pd,
    output logic [DW-1:0]           wb_data,
    output logic [FU_NUM-1:0]       wb_grant,
    input  logic                    flush_valid,
    output logic [15:0]             stall_cnt
);

    localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    logic [FU_NUM-1:0]     slot_vld_q, slot_vld_d;
    cdb_pkt_t [FU_NUM-1:0] slot_pkt_q, slot_pkt_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
    // A stalled grant is latched so a newly filled slot cannot preempt it.
    logic                  hold_q, hold_d;
    logic [FU_NUM-1:0]     hold_gnt_q, hold_gnt_d;

    logic [FU_NUM-1:0]     arb_gnt;
    logic [FU_NUM-1:0]     grant;
    logic                  fire;
    logic                  stall;
    cdb_pkt_t              sel_pkt;
    logic [PTR_W-1:0]      gnt_idx;

    rr_arbiter #(.N(FU_NUM), .PTR_W(PTR_W)) u_rr (
        .req (slot_vld_q),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Broadcast mux, handshake and per-FU ready.
    always_comb begin
        grant    = hold_q ? hold_gnt_q : arb_gnt;
        wb_valid = (|slot_vld_q) && !flush_valid;
        fire     = wb_valid && wb_ready;
        stall    = wb_valid && !wb_ready;
        sel_pkt  = '0;
        gnt_idx  = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (grant[i]) begin
                sel_pkt = slot_pkt_q[i];
                gnt_idx = PTR_W'(i);
            end
        end
        wb_grant      = wb_valid ? grant : '0;
        wb_rob_idx    = wb_valid ? sel_pkt.rob_idx : '0;
        wb_epoch      = wb_valid ? sel_pkt.epoch : '0;
        wb_mispredict = wb_valid ? sel_pkt.mispredict : 1'b0;
        wb_pd         = wb_valid ? sel_pkt.pd : '0;
        wb_data       = wb_valid ? sel_pkt.data : '0;
        fu_ready      = flush_valid ? '0 : (~slot_vld_q | (grant & {FU_NUM{fire}}));
        stall_cnt     = stall_cnt_q;
    end

    // Slot fill/drain, pointer advance, grant hold and stall counting.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_pkt_d = slot_pkt_q;
        for (int i = 0; i < FU_NUM; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
                slot_vld_d[i] = 1'b1;
                slot_pkt_d[i] = fu_result[i];
            end else if (grant[i] && fire) begin
                slot_vld_d[i] = 1'b0;
            end
        end
        if (flush_valid) begin
            slot_vld_d = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (gnt_idx == PTR_W'(FU_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end
        hold_d      = stall;
        hold_gnt_d  = grant;
        stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q  <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            hold_q      <= 1'b0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            hold_q      <= hold_d;
        end
    end

    // Packet payloads are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        slot_pkt_q <= slot_pkt_d;
        hold_gnt_q <= hold_gnt_d;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [FU_NUM-1:0]     fu_valid;
    logic [FU_NUM-1:0]     fu_ready;
    cdb_pkt_t [FU_NUM-1:0] fu_result;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [ROB_W-1:0]      wb_rob_idx;
    logic [1:0]            wb_epoch;
    logic                  wb_mispredict;
    logic [PHYS_W-1:0]     wb_pd;
    logic [DW-1:0]         wb_data;
    logic [FU_NUM-1:0]     wb_grant;
    logic                  flush_valid;
    logic [15:0]           stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_result     (fu_result),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rob_idx    (wb_rob_idx),
        .wb_epoch      (wb_epoch),
        .wb_mispredict (wb_mispredict),
        .wb_pd         (wb_pd),
        .wb_data       (wb_data),
        .wb_grant      (wb_grant),
        .flush_valid   (flush_valid),
        .stall_cnt     (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic cdb_pkt_t mkpkt(input logic [3:0] rob, input logic [5:0] pd, input logic [31:0] data);
        cdb_pkt_t p;
        p.rob_idx    = rob;
        p.epoch      = rob[1:0];
        p.mispredict = rob[0];
        p.pd         = pd;
        p.data       = data;
        return p;
    endfunction

    // Advance one clock; inputs are then driven 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fu_valid = '0;
        flush_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fu_valid = '0;
        wb_ready = 1'b0;
        flush_valid = 1'b0;
        for (int i = 0; i < FU_NUM; i++) fu_result[i] = '0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_grant", 32'(wb_grant), 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_fu_ready", 32'(fu_ready), 32'hF);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        cyc();

        // FU0 and FU2 together: FU0 first, then FU2, then idle
        fu_valid = 4'b0101;
        fu_result[0] = mkpkt(4'd1, 6'd10, 32'hA0);
        fu_result[2] = mkpkt(4'd2, 6'd12, 32'hA2);
        wb_ready = 1'b1;
        #1;
        check("a0_wb_valid", 32'(wb_valid), 32'd0);
        cyc();
        fu_valid = '0;
        #1;
        check("a1_grant", 32'(wb_grant), 32'b0001);
        check("a1_rob", 32'(wb_rob_idx), 32'd1);
        check("a1_data", wb_data, 32'hA0);
        check("a1_misp", 32'(wb_mispredict), 32'd1);
        cyc();
        #1;
        check("a2_grant", 32'(wb_grant), 32'b0100);
        check("a2_pd", 32'(wb_pd), 32'd12);
        check("a2_epoch", 32'(wb_epoch), 32'd2);
        cyc();
        #1;
        check("a3_wb_valid", 32'(wb_valid), 32'd0);

        // Stall on FU1 (rr_ptr now 3); FU0 arriving mid-stall must not preempt
        fu_valid = 4'b0010;
        fu_result[1] = mkpkt(4'd4, 6'd5, 32'hB1);
        wb_ready = 1'b0;
        cyc();
        fu_valid = 4'b0001;
        fu_result[0] = mkpkt(4'd8, 6'd9, 32'hB0);
        #1;
        check("b1_grant", 32'(wb_grant), 32'b0010);
        check("b1_fu_ready", 32'(fu_ready), 32'b1101);
        cyc();
        fu_valid = '0;
        #1;
        check("b2_grant_nopreempt", 32'(wb_grant), 32'b0010);
        check("b2_pd", 32'(wb_pd), 32'd5);
        check("b2_stall", 32'(stall_cnt), 32'd1);
        cyc();
        #1;
        check("b3_grant", 32'(wb_grant), 32'b0010);
        check("b3_rdy1", 32'(fu_ready[1]), 32'd0);
        cyc();
        wb_ready = 1'b1;
        #1;
        check("b4_stall", 32'(stall_cnt), 32'd3);
        check("b4_pd", 32'(wb_pd), 32'd5);
        check("b4_rdy1_drain", 32'(fu_ready[1]), 32'd1);
        cyc();
        #1;
        check("b5_grant", 32'(wb_grant), 32'b0001);
        check("b5_pd", 32'(wb_pd), 32'd9);
        cyc();
        #1;
        check("b6_wb_valid", 32'(wb_valid), 32'd0);
        check("b6_stall_kept", 32'(stall_cnt), 32'd3);

        // All slots full with continuous refill: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < FU_NUM; i++) fu_result[i] = mkpkt(4'(i), 6'(i + 20), 32'(i));
        fu_valid = 4'hF;
        wb_ready = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("c_grant", 32'(wb_grant), 32'(1 << (k % 4)));
            check("c_rob", 32'(wb_rob_idx), 32'(k % 4));
            check("c_fu_ready", 32'(fu_ready), 32'(1 << (k % 4)));
            cyc();
        end

        // Flush with slots 0 and 3 full and rr_ptr=1
        do_reset();
        fu_valid = 4'b1001;
        fu_result[0] = mkpkt(4'd1, 6'd1, 32'hC0);
        fu_result[3] = mkpkt(4'd3, 6'd3, 32'hC3);
        wb_ready = 1'b0;
        cyc();
        fu_valid = '0;
        #1;
        check("d1_grant", 32'(wb_grant), 32'b0001);
        cyc();
        cyc();
        cyc();
        wb_ready = 1'b1;
        fu_valid = 4'b0001;
        fu_result[0] = mkpkt(4'd5, 6'd7, 32'hC5);
        #1;
        check("d4_fu_ready", 32'(fu_ready), 32'b0111);
        cyc();
        flush_valid = 1'b1;
        fu_valid = 4'b0010;
        fu_result[1] = mkpkt(4'd6, 6'd6, 32'hC6);
        #1;
        check("d5_wb_valid", 32'(wb_valid), 32'd0);
        check("d5_grant", 32'(wb_grant), 32'd0);
        check("d5_fu_ready", 32'(fu_ready), 32'd0);
        check("d5_rob", 32'(wb_rob_idx), 32'd0);
        cyc();
        flush_valid = 1'b0;
        fu_valid = '0;
        #1;
        check("d6_wb_valid", 32'(wb_valid), 32'd0);
        check("d6_fu_ready", 32'(fu_ready), 32'hF);
        cyc();
        fu_valid = 4'b1001;
        fu_result[0] = mkpkt(4'd2, 6'd2, 32'hD0);
        fu_result[3] = mkpkt(4'd4, 6'd4, 32'hD3);
        cyc();
        fu_valid = '0;
        #1;
        check("d8_grant_ptr_kept", 32'(wb_grant), 32'b1000);
        check("d8_rob", 32'(wb_rob_idx), 32'd4);
        cyc();
        #1;
        check("d9_grant", 32'(wb_grant), 32'b0001);
        cyc();
        #1;
        check("d10_wb_valid", 32'(wb_valid), 32'd0);

        // Drain and refill slot 2 in the same cycle
        fu_valid = 4'b0100;
        fu_result[2] = mkpkt(4'd3, 6'd3, 32'hE3);
        wb_ready = 1'b0;
        cyc();
        fu_result[2] = mkpkt(4'd7, 6'd17, 32'hE7);
        wb_ready = 1'b1;
        #1;
        check("e1_rdy2", 32'(fu_ready[2]), 32'd1);
        check("e1_rob", 32'(wb_rob_idx), 32'd3);
        cyc();
        fu_valid = '0;
        #1;
        check("e2_wb_valid", 32'(wb_valid), 32'd1);
        check("e2_rob", 32'(wb_rob_idx), 32'd7);
        check("e2_grant", 32'(wb_grant), 32'b0100);
        cyc();
        #1;
        check("e3_wb_valid", 32'(wb_valid), 32'd0);

        // Long stall: saturation, then reset mid-broadcast
        do_reset();
        fu_valid = 4'b0001;
        fu_result[0] = mkpkt(4'd9, 6'd9, 32'hF9);
        wb_ready = 1'b0;
        cyc();
        fu_valid = '0;
        repeat (65534) cyc();
        check("f_stall_fffe", 32'(stall_cnt), 32'hFFFE);
        cyc();
        check("f_stall_ffff", 32'(stall_cnt), 32'hFFFF);
        repeat (4464) cyc();
        check("f_stall_hold", 32'(stall_cnt), 32'hFFFF);
        check("f_wb_valid", 32'(wb_valid), 32'd1);
        check("f_rob", 32'(wb_rob_idx), 32'd9);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("f_rst_stall", 32'(stall_cnt), 32'd0);
        check("f_rst_wb_valid", 32'(wb_valid), 32'd0);
        check("f_rst_fu_ready", 32'(fu_ready), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
